i2c_target: RTL and testbench

- I2C target (responder) that answers an external I2C initiator, such as the bit-banged I2C master on the peripheral bus.
- Exposes a 256-byte register space through a simple local register-port handshake.
- Supports a pointer write followed by auto-incrementing data writes, and auto-incrementing reads.
- Supports repeated START. 7-bit addressing, standard/fast mode, no clock stretching.

---
 rtl/i2c_target.sv | 224 ++++++++++++++++++++++
 tb/tb_i2c_target.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// I2C target exposing a 256-byte register space: pointer write, auto-increment writes/reads, repeated START.
// Bus events lag the pins by 2+FILTER cycles; the target never stretches SCL, so the register port must keep up.
module i2c_target #(
    parameter logic [6:0] ADDRESS = 7'h50,
    parameter int         FILTER  = 3
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       I2C_SCL,
    inout  wire        I2C_SDA,
    output logic [7:0] o_reg_addr,
    output logic [7:0] o_reg_wdata,
    output logic       o_reg_write,
    output logic       o_reg_read,
    input  logic [7:0] i_reg_rdata,
    output logic       o_busy
);
    localparam logic [3:0] FLT_MAX = 4'(FILTER - 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    logic [1:0] scl_s_q, sda_s_q;
    logic [3:0] scl_cnt_q, sda_cnt_q;
    logic       scl_f_q, sda_f_q, scl_p_q, sda_p_q;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            scl_s_q   <= 2'b11;
            sda_s_q   <= 2'b11;
            scl_cnt_q <= '0;
            sda_cnt_q <= '0;
            scl_f_q   <= 1'b1;
            sda_f_q   <= 1'b1;
            scl_p_q   <= 1'b1;
            sda_p_q   <= 1'b1;
        end else begin
            scl_s_q <= {scl_s_q[0], I2C_SCL};
            sda_s_q <= {sda_s_q[0], I2C_SDA};
            scl_p_q <= scl_f_q;
            sda_p_q <= sda_f_q;
            // A line only flips after FILTER consecutive samples disagree with its filtered value
            if (scl_s_q[1] == scl_f_q) begin
                scl_cnt_q <= '0;
            end else if (scl_cnt_q == FLT_MAX) begin
                scl_cnt_q <= '0;
                scl_f_q   <= scl_s_q[1];
            end else begin
                scl_cnt_q <= scl_cnt_q + 4'd1;
            end
            if (sda_s_q[1] == sda_f_q) begin
                sda_cnt_q <= '0;
            end else if (sda_cnt_q == FLT_MAX) begin
                sda_cnt_q <= '0;
                sda_f_q   <= sda_s_q[1];
            end else begin
                sda_cnt_q <= sda_cnt_q + 4'd1;
            end
        end
    end

    logic scl_rise, scl_fall, start_ev, stop_ev;
    assign scl_rise = scl_f_q & ~scl_p_q;
    assign scl_fall = ~scl_f_q & scl_p_q;
    assign start_ev = scl_f_q & sda_p_q & ~sda_f_q;
    assign stop_ev  = scl_f_q & ~sda_p_q & sda_f_q;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d, addr_q, addr_d, wdata_q, wdata_d;
    logic       sda_drv_q, sda_drv_d, busy_q, busy_d, write_q, write_d, read_q, read_d;
    logic       rw_q, rw_d, rd_cap_q, rd_cap_d, rd_drv_q, rd_drv_d;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            sda_drv_q <= 1'b0;
            busy_q    <= 1'b0;
            write_q   <= 1'b0;
            read_q    <= 1'b0;
            rw_q      <= 1'b0;
            rd_cap_q  <= 1'b0;
            rd_drv_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            sda_drv_q <= sda_drv_d;
            busy_q    <= busy_d;
            write_q   <= write_d;
            read_q    <= read_d;
            rw_q      <= rw_d;
            rd_cap_q  <= rd_cap_d;
            rd_drv_q  <= rd_drv_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        sda_drv_d = sda_drv_q;
        busy_d    = busy_q;
        write_d   = 1'b0;
        read_d    = 1'b0;
        rw_d      = rw_q;
        rd_cap_d  = read_q;
        rd_drv_d  = rd_drv_q;

        if (write_q) addr_d = addr_q + 8'd1;

        // First read byte is driven as soon as it lands; later bytes wait for the ACK clock to fall
        if (rd_cap_q && state_q == RDATA) begin
            shift_d = i_reg_rdata;
            cnt_d   = 4'd0;
            if (rd_drv_q) begin
                sda_drv_d = ~i_reg_rdata[7];
                shift_d   = {i_reg_rdata[6:0], 1'b0};
                cnt_d     = 4'd1;
            end
        end

        unique case (state_q)
            ADDR, PTR, WDATA: begin
                if (scl_rise && cnt_q != 4'd8) begin
                    shift_d = {shift_q[6:0], sda_f_q};
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        if (state_q == ADDR) begin
                            rw_d = sda_f_q;
                            if (shift_q[6:0] != ADDRESS) state_d = IGNORE;
                        end else if (state_q == PTR) begin
                            addr_d = {shift_q[6:0], sda_f_q};
                        end else begin
                            wdata_d = {shift_q[6:0], sda_f_q};
                            write_d = 1'b1;
                        end
                    end
                end else if (scl_fall && cnt_q == 4'd8) begin
                    sda_drv_d = 1'b1;
                    cnt_d     = 4'd0;
                    if (state_q == ADDR) begin
                        busy_d  = 1'b1;
                        state_d = ADDR_ACK;
                    end else begin
                        state_d = (state_q == PTR) ? PTR_ACK : WDATA_ACK;
                    end
                end
            end
            ADDR_ACK: begin
                if (scl_fall) begin
                    cnt_d = 4'd0;
                    if (rw_q) begin
                        read_d   = 1'b1;
                        rd_drv_d = 1'b1;
                        state_d  = RDATA;
                    end else begin
                        sda_drv_d = 1'b0;
                        state_d   = PTR;
                    end
                end
            end
            PTR_ACK, WDATA_ACK: begin
                if (scl_fall) begin
                    sda_drv_d = 1'b0;
                    state_d   = WDATA;
                end
            end
            RDATA: begin
                if (scl_fall) begin
                    if (cnt_q == 4'd8) begin
                        sda_drv_d = 1'b0;
                        state_d   = RDATA_ACK;
                    end else begin
                        sda_drv_d = ~shift_q[7];
                        shift_d   = {shift_q[6:0], 1'b0};
                        cnt_d     = cnt_q + 4'd1;
                    end
                end
            end
            RDATA_ACK: begin
                if (scl_rise) begin
                    if (!sda_f_q) begin
                        addr_d   = addr_q + 8'd1;
                        read_d   = 1'b1;
                        rd_drv_d = 1'b0;
                        state_d  = RDATA;
                    end else begin
                        state_d = IGNORE;
                    end
                end
            end
            default: ;
        endcase

        if (start_ev) begin
            state_d   = ADDR;
            cnt_d     = 4'd0;
            sda_drv_d = 1'b0;
            busy_d    = 1'b0;
        end
        if (stop_ev) begin
            state_d   = IDLE;
            sda_drv_d = 1'b0;
            busy_d    = 1'b0;
        end
    end

    assign I2C_SDA     = sda_drv_q ? 1'b0 : 1'bz;
    assign o_reg_addr  = addr_q;
    assign o_reg_wdata = wdata_q;
    assign o_reg_write = write_q;
    assign o_reg_read  = read_q;
    assign o_busy      = busy_q;
endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-level I2C initiator, registered register-space model, strobe scoreboard.
module tb_i2c_target;
    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       scl = 1'b1;
    logic       m_sda_oe = 1'b0;
    logic [7:0] o_reg_addr, o_reg_wdata, reg_rdata = 8'h00;
    logic       o_reg_write, o_reg_read, o_busy;
    wire        sda;

    pullup (sda);
    assign sda = m_sda_oe ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_target #(.ADDRESS(7'h50), .FILTER(3)) dut (
        .i_clock    (clk),
        .i_reset    (i_reset),
        .I2C_SCL    (scl),
        .I2C_SDA    (sda),
        .o_reg_addr (o_reg_addr),
        .o_reg_wdata(o_reg_wdata),
        .o_reg_write(o_reg_write),
        .o_reg_read (o_reg_read),
        .i_reg_rdata(reg_rdata),
        .o_busy     (o_busy)
    );

    always @(posedge clk) if (o_reg_read) reg_rdata <= o_reg_addr ^ 8'h5A;

    typedef struct {
        bit         is_wr;
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   tgt_low_cnt = 0;

    // Every wait goes through here so strobes are scored on the cycle they appear
    task automatic cycles(input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (!m_sda_oe && sda === 1'b0) tgt_low_cnt++;
            if (o_reg_write || o_reg_read) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe: got wr=%0b rd=%0b addr=%02h, required no strobe",
                             o_reg_write, o_reg_read, o_reg_addr);
                end else begin
                    e = exp_q.pop_front();
                    if ({o_reg_write, o_reg_read} !== (e.is_wr ? 2'b10 : 2'b01) || o_reg_addr !== e.addr ||
                        (e.is_wr && o_reg_wdata !== e.data)) begin
                        errors++;
                        $display("FAIL strobe: got wr=%0b rd=%0b addr=%02h wdata=%02h, required wr=%0b addr=%02h wdata=%02h",
                                 o_reg_write, o_reg_read, o_reg_addr, o_reg_wdata, e.is_wr, e.addr, e.data);
                    end
                end
            end
        end
    endtask

    task automatic push(input bit is_wr, input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        e.is_wr = is_wr;
        e.addr  = a;
        e.data  = d;
        exp_q.push_back(e);
    endtask

    task automatic bus_start();
        m_sda_oe = 1'b0; cycles(Q);
        m_sda_oe = 1'b1; cycles(Q);
        scl = 1'b0;      cycles(Q);
    endtask

    task automatic bus_rstart();
        m_sda_oe = 1'b0; cycles(Q);
        scl = 1'b1;      cycles(Q);
        m_sda_oe = 1'b1; cycles(Q);
        scl = 1'b0;      cycles(Q);
    endtask

    task automatic bus_stop();
        m_sda_oe = 1'b1; cycles(Q);
        scl = 1'b1;      cycles(Q);
        m_sda_oe = 1'b0; cycles(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, input int glitch_bit, output bit ack);
        for (int i = 7; i >= 0; i--) begin
            m_sda_oe = ~b[i]; cycles(Q);
            scl = 1'b1;
            if (i == glitch_bit) begin
                cycles(Q); scl = 1'b0; cycles(1); scl = 1'b1; cycles(Q - 1);
            end else begin
                cycles(2 * Q);
            end
            scl = 1'b0; cycles(Q);
        end
        m_sda_oe = 1'b0; cycles(Q);
        scl = 1'b1;      cycles(Q);
        ack = (sda === 1'b0);
        cycles(Q);
        scl = 1'b0;      cycles(Q);
    endtask

    task automatic read_byte(input bit give_ack, output logic [7:0] b);
        m_sda_oe = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            cycles(Q); scl = 1'b1;
            cycles(Q); b[i] = (sda === 1'b1);
            cycles(Q); scl = 1'b0;
            cycles(Q);
        end
        m_sda_oe = give_ack; cycles(Q);
        scl = 1'b1;          cycles(2 * Q);
        scl = 1'b0;          cycles(Q);
        m_sda_oe = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (o_reg_addr !== 8'h00)  begin errors++; $display("FAIL reset_addr: got %02h, required 00", o_reg_addr); end
        checks++; if (o_reg_wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata: got %02h, required 00", o_reg_wdata); end
        checks++; if (o_reg_write !== 1'b0)  begin errors++; $display("FAIL reset_write: got %0b, required 0", o_reg_write); end
        checks++; if (o_reg_read !== 1'b0)   begin errors++; $display("FAIL reset_read: got %0b, required 0", o_reg_read); end
        checks++; if (o_busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %0b, required 0", o_busy); end
        checks++; if (sda !== 1'b1)          begin errors++; $display("FAIL reset_sda: got %0b, required released (1)", sda); end
        i_reset = 1'b0;
        cycles(10);
    endtask

    task automatic test_write();
        bit ack;
        logic [7:0] bytes [4] = '{8'hA0, 8'h10, 8'h11, 8'h22};
        push(1'b1, 8'h10, 8'h11);
        push(1'b1, 8'h11, 8'h22);
        bus_start();
        for (int i = 0; i < 4; i++) begin
            write_byte(bytes[i], -1, ack);
            checks++; if (!ack) begin errors++; $display("FAIL write_ack[%0d]: got NACK, required ACK", i); end
            if (i == 0) begin
                checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL write_busy: got %0b, required 1", o_busy); end
            end
        end
        bus_stop();
        cycles(10);
        checks++; if (o_reg_addr !== 8'h12) begin errors++; $display("FAIL write_addr_after: got %02h, required 12", o_reg_addr); end
        checks++; if (o_busy !== 1'b0)      begin errors++; $display("FAIL write_busy_after: got %0b, required 0", o_busy); end
        checks++; if (exp_q.size() != 0)    begin errors++; $display("FAIL write_pending: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_read_rs();
        bit ack;
        logic [7:0] rb;
        logic [7:0] want [3] = '{8'hA4, 8'hA5, 8'h5A};
        push(1'b0, 8'hFE, 8'h00);
        push(1'b0, 8'hFF, 8'h00);
        push(1'b0, 8'h00, 8'h00);
        bus_start();
        write_byte(8'hA0, -1, ack);
        checks++; if (!ack) begin errors++; $display("FAIL read_addr_w_ack: got NACK, required ACK"); end
        write_byte(8'hFE, -1, ack);
        checks++; if (!ack) begin errors++; $display("FAIL read_ptr_ack: got NACK, required ACK"); end
        bus_rstart();
        write_byte(8'hA1, -1, ack);
        checks++; if (!ack) begin errors++; $display("FAIL read_addr_r_ack: got NACK, required ACK"); end
        for (int i = 0; i < 3; i++) begin
            read_byte(i < 2, rb);
            checks++; if (rb !== want[i]) begin errors++; $display("FAIL read_data[%0d]: got %02h, required %02h", i, rb, want[i]); end
        end
        cycles(4);
        checks++; if (sda !== 1'b1) begin errors++; $display("FAIL read_release_after_nack: got %0b, required 1", sda); end
        bus_stop();
        cycles(10);
        checks++; if (o_reg_addr !== 8'h00) begin errors++; $display("FAIL read_addr_wrap: got %02h, required 00", o_reg_addr); end
        checks++; if (exp_q.size() != 0)    begin errors++; $display("FAIL read_pending: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_mismatch();
        bit ack;
        int low0;
        logic [7:0] bytes [4] = '{8'h42, 8'h10, 8'h20, 8'h30};
        low0 = tgt_low_cnt;
        bus_start();
        for (int i = 0; i < 4; i++) begin
            write_byte(bytes[i], -1, ack);
            checks++; if (ack) begin errors++; $display("FAIL mismatch_ack[%0d]: got ACK, required NACK", i); end
            checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL mismatch_busy[%0d]: got %0b, required 0", i, o_busy); end
        end
        bus_stop();
        cycles(10);
        checks++; if (tgt_low_cnt != low0) begin errors++; $display("FAIL mismatch_sda_driven: got %0d cycles low, required 0", tgt_low_cnt - low0); end
        checks++; if (o_reg_addr !== 8'h00) begin errors++; $display("FAIL mismatch_addr: got %02h, required 00", o_reg_addr); end
    endtask

    task automatic test_glitch();
        bit ack;
        push(1'b1, 8'h30, 8'hB6);
        bus_start();
        write_byte(8'hA0, -1, ack);
        write_byte(8'h30, -1, ack);
        write_byte(8'hB6, 4, ack);
        checks++; if (!ack) begin errors++; $display("FAIL glitch_ack: got NACK, required ACK"); end
        bus_stop();
        cycles(10);
        checks++; if (o_reg_addr !== 8'h31) begin errors++; $display("FAIL glitch_addr: got %02h, required 31", o_reg_addr); end
        checks++; if (exp_q.size() != 0)    begin errors++; $display("FAIL glitch_pending: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_abort();
        bit ack;
        logic [7:0] b = 8'h9C;
        bus_start();
        write_byte(8'hA0, -1, ack);
        write_byte(8'h40, -1, ack);
        for (int i = 7; i >= 4; i--) begin
            m_sda_oe = ~b[i]; cycles(Q);
            scl = 1'b1; cycles(2 * Q);
            scl = 1'b0; cycles(Q);
        end
        bus_stop();
        cycles(10);
        checks++; if (o_reg_addr !== 8'h40) begin errors++; $display("FAIL abort_addr: got %02h, required 40", o_reg_addr); end
        checks++; if (o_busy !== 1'b0)      begin errors++; $display("FAIL abort_busy: got %0b, required 0", o_busy); end
        push(1'b1, 8'h40, 8'h77);
        bus_start();
        write_byte(8'hA0, -1, ack);
        checks++; if (!ack) begin errors++; $display("FAIL abort_next_ack: got NACK, required ACK"); end
        write_byte(8'h40, -1, ack);
        write_byte(8'h77, -1, ack);
        bus_stop();
        cycles(10);
        checks++; if (o_reg_addr !== 8'h41) begin errors++; $display("FAIL abort_next_addr: got %02h, required 41", o_reg_addr); end
        checks++; if (exp_q.size() != 0)    begin errors++; $display("FAIL abort_pending: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_read();
        bit ack;
        push(1'b0, 8'h5A, 8'h00);
        bus_start();
        write_byte(8'hA0, -1, ack);
        write_byte(8'h5A, -1, ack);
        bus_rstart();
        write_byte(8'hA1, -1, ack);
        cycles(2);
        checks++; if (sda !== 1'b0) begin errors++; $display("FAIL rst_pre_drive: got %0b, required 0 (bit7 of 00)", sda); end
        i_reset = 1'b1;
        cycles(1);
        checks++; if (sda !== 1'b1)          begin errors++; $display("FAIL rst_sda: got %0b, required released (1)", sda); end
        checks++; if (o_busy !== 1'b0)       begin errors++; $display("FAIL rst_busy: got %0b, required 0", o_busy); end
        checks++; if (o_reg_addr !== 8'h00)  begin errors++; $display("FAIL rst_addr: got %02h, required 00", o_reg_addr); end
        checks++; if (o_reg_wdata !== 8'h00) begin errors++; $display("FAIL rst_wdata: got %02h, required 00", o_reg_wdata); end
        checks++; if ({o_reg_write, o_reg_read} !== 2'b00) begin errors++; $display("FAIL rst_strobes: got %02b, required 00", {o_reg_write, o_reg_read}); end
        cycles(3);
        i_reset = 1'b0;
        scl = 1'b1;
        cycles(20);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rst_pending: got %0d left, required 0", exp_q.size()); end
    endtask

    initial begin
        cycles(5);
        test_reset();
        test_write();
        test_read_rs();
        test_mismatch();
        test_glitch();
        test_abort();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end
endmodule
